// File: rtl/max4_pkg.sv
// Shared types and defaults for the 4-input max feeder path.
package max4_pkg;
    localparam int DATA_W    = 9;
    localparam int FRAME_LEN = 4;
    localparam int SEQ_W     = 8;

    // Most-negative sample, used to fill lanes that must never win the max.
    localparam logic signed [DATA_W-1:0] PAD = {1'b1, {(DATA_W-1){1'b0}}};

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef sample_t [FRAME_LEN-1:0]  frame_t;
endpackage

// File: rtl/max4_frame_bank.sv
// One frame buffer: lane storage, written-lane mask, full flag and frame seq.
module max4_frame_bank
    import max4_pkg::*;
#(
    parameter int DATA_W    = max4_pkg::DATA_W,
    parameter int FRAME_LEN = max4_pkg::FRAME_LEN,
    parameter int SEQ_W     = max4_pkg::SEQ_W,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_lane,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          close,
    input  logic [SEQ_W-1:0]              seq_in,
    input  logic                          clr,
    output logic                          full,
    output logic [FRAME_LEN-1:0]          lanes,
    output logic [DATA_W*FRAME_LEN-1:0]   data,
    output logic [SEQ_W-1:0]              seq
);
    localparam logic [DATA_W-1:0] PAD_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic [FRAME_LEN-1:0][DATA_W-1:0] data_q, data_d;
    logic [FRAME_LEN-1:0]             mask_q, mask_d;
    logic                             full_q, full_d;
    logic [SEQ_W-1:0]                 seq_q, seq_d;

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        full_d = full_q;
        seq_d  = seq_q;
        if (wr_en) begin
            data_d[wr_lane] = wr_data;
            mask_d[wr_lane] = 1'b1;
            if (close) begin
                // Pad after the closing write so that lane keeps its sample.
                for (int i = 0; i < FRAME_LEN; i++) begin
                    if (!mask_d[i]) data_d[i] = PAD_V;
                end
                full_d = 1'b1;
                seq_d  = seq_in;
            end
        end
        if (clr) begin
            full_d = 1'b0;
            mask_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mask_q <= '0;
            full_q <= 1'b0;
            seq_q  <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            full_q <= full_d;
            seq_q  <= seq_d;
        end
    end

    assign full  = full_q;
    assign lanes = mask_q;
    assign data  = data_q;
    assign seq   = seq_q;
endmodule

// File: rtl/max4_frame_feeder.sv
// Packs a sample stream into ping-pong double-buffered frames for the max stage.
module max4_frame_feeder
    import max4_pkg::*;
#(
    parameter int DATA_W    = max4_pkg::DATA_W,
    parameter int FRAME_LEN = max4_pkg::FRAME_LEN,
    parameter int SEQ_W     = max4_pkg::SEQ_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W*FRAME_LEN-1:0] out_data,
    output logic [FRAME_LEN-1:0]        out_lanes,
    output logic [SEQ_W-1:0]            out_seq
);
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [SEQ_W-1:0] seq_q, seq_d;

    logic [1:0]                             bank_full;
    logic [1:0][FRAME_LEN-1:0]              bank_lanes;
    logic [1:0][DATA_W*FRAME_LEN-1:0]       bank_data;
    logic [1:0][SEQ_W-1:0]                  bank_seq;
    logic [1:0]                             bank_wr, bank_clr;

    logic accept, close, pop;

    // Ready looks only at registered bank state, never at out_ready.
    assign in_ready  = !rst && !bank_full[wr_bank_q];
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_last || (wr_idx_q == IDX_W'(FRAME_LEN-1)));
    assign out_valid = bank_full[rd_bank_q];
    assign pop       = out_valid && out_ready;

    assign out_data  = bank_data[rd_bank_q];
    assign out_lanes = bank_lanes[rd_bank_q];
    assign out_seq   = bank_seq[rd_bank_q];

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        seq_d     = seq_q;
        bank_wr   = '0;
        bank_clr  = '0;
        if (accept) begin
            bank_wr[wr_bank_q] = 1'b1;
            wr_idx_d           = wr_idx_q + IDX_W'(1);
        end
        if (close) begin
            wr_idx_d  = '0;
            wr_bank_d = !wr_bank_q;
            seq_d     = seq_q + SEQ_W'(1);
        end
        if (pop) begin
            bank_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            seq_q     <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            seq_q     <= seq_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        max4_frame_bank #(
            .DATA_W    (DATA_W),
            .FRAME_LEN (FRAME_LEN),
            .SEQ_W     (SEQ_W),
            .IDX_W     (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_wr[b]),
            .wr_lane (wr_idx_q),
            .wr_data (in_data),
            .close   (close),
            .seq_in  (seq_q),
            .clr     (bank_clr[b]),
            .full    (bank_full[b]),
            .lanes   (bank_lanes[b]),
            .data    (bank_data[b]),
            .seq     (bank_seq[b])
        );
    end
endmodule

// File: doc/max4_frame_feeder.md
Name: max4_frame_feeder

Overview:
Upstream feeder for the 4-input max finder. Accepts a valid/ready stream of signed samples and packs them into 4-sample frames. Frames are ping-pong double-buffered, so input runs at full rate while the max stage consumes one frame per handshake. Short frames closed early by in_last are padded with the most-negative value so they cannot win the max.

Parameters:
DATA_W, 9, sample width, signed two's complement
FRAME_LEN, 4, samples per frame (the max stage takes exactly 4)
SEQ_W, 8, width of the frame sequence counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  feeder can accept a sample
in_data  in  DATA_W  signed sample
in_last  in  1  sample closes the current frame early
out_valid  out  1  full frame available
out_ready  in  1  max stage accepts frame
out_data  out  DATA_W*FRAME_LEN  lane i at [DATA_W*i +: DATA_W]; lane 0 = first sample
out_lanes  out  FRAME_LEN  bit i set = lane i holds a real sample
out_seq  out  SEQ_W  frame sequence number

Behaviour:
Reset and clocking:
- One clock domain; asynchronous active-high reset.
- While rst=1: in_ready=0, out_valid=0, out_data=0, out_lanes=0, out_seq=0. Both banks are empty, wr_bank=rd_bank=0, wr_idx=0, seq counter=0.

State:
- Two banks, each holding FRAME_LEN samples, a lane mask and a full flag.
- wr_bank, rd_bank: 1-bit pointers.
- wr_idx: 0..FRAME_LEN-1.

Write side:
- in_ready = !rst && !full[wr_bank]. It depends on registered state only, never combinationally on out_ready.
- Accept = in_valid && in_ready. Store in_data at lane wr_idx of wr_bank and set that lane's mask bit.
- Frame close happens on accept with wr_idx==FRAME_LEN-1 or in_last=1. On close:
  - full[wr_bank]<=1
  - unwritten lanes <= PAD = -2^(DATA_W-1) (9'h100), mask bits stay 0
  - bank takes seq counter value, then seq counter increments and wraps 2^SEQ_W-1 -> 0
  - wr_idx<=0, wr_bank toggles
- in_last on the final lane has the same effect as a normal close.
- in_valid=0 leaves a partially filled bank waiting. There is no timeout.

Read side:
- out_valid = full[rd_bank]. out_data, out_lanes and out_seq come straight from the rd_bank registers.
- Outputs hold stable while out_valid && !out_ready.
- On out_valid && out_ready: full[rd_bank]<=0, the mask is cleared, rd_bank toggles.
- When out_valid=0, out_data/out_lanes/out_seq are don't-care (the implementation holds the last values).

Latency and throughput:
- Latency: out_valid rises the cycle after the closing sample is accepted.
- Sustained throughput is 1 sample/cycle with out_ready held at 1.

Boundaries:
- Freeing bank A and closing bank B in the same cycle is legal and independent.
- A bank freed at cycle t shows in_ready=1 at t+1.
- Both banks full: in_ready=0, and in_data is ignored.
- A partial frame is never emitted without in_last.
- Reset mid-frame discards partial and full frames, and seq restarts at 0.
- Width rule: samples are stored unmodified and there is no arithmetic on data. The seq counter wraps modulo 2^SEQ_W.

Decomposition:
- Shared package max4_pkg holds:
  - DATA_W, FRAME_LEN, SEQ_W defaults
  - PAD constant
  - typedef sample_t (signed [DATA_W-1:0])
  - typedef frame_t (array of FRAME_LEN sample_t)
- Sub-module max4_frame_bank (lane storage, mask, full flag, seq, write/clear/pad controls) is instantiated twice. The top holds the pointers, wr_idx, seq counter and handshakes.

Test Plan:
1. Reset:
   - Assert rst for 3 cycles mid-stream -> in_ready=0, out_valid=0, out_seq=0 during rst.
   - Release -> in_ready=1 next cycle, then first frame has seq 0.
2. Single full frame: with out_ready=1, send 5, -3, 100, -256 back-to-back -> out_valid one cycle after the 4th accept, with:
   - lanes {5, -3, 100, -256}
   - out_lanes=4'b1111
   - out_seq=0
3. Partial frame: send 7, then -1 with in_last=1 ->
   - lanes {7, -1, -256, -256}, out_lanes=4'b0011
   - next frame starts at lane 0
4. Backpressure: with out_ready=0, offer 12 samples 1..12 ->
   - exactly 8 accepted, in_ready=0
   - out_data held at {1,2,3,4} with seq 0
   - raise out_ready -> frames {1..4} seq 0, {5..8} seq 1, then 9..12 accepted giving seq 2
5. Full throughput: with out_ready=1 and in_valid=1 for 16 samples ->
   - in_ready never drops
   - 4 frames with seq 0, 1, 2, 3, each 4 cycles apart
6. Wrap and mid-frame reset:
   - 257 frames -> seq runs 254, 255, 0.
   - Assert rst after 2 samples of a frame -> no frame emitted, and the next completed frame has seq 0.
